coeff_sel_arbiter: RTL and testbench
====================================

// Module: coeff_sel_arbiter
// PURPOSE
//  Single-clock arbiter/sequencer that owns the coefficient-source select (o_sel) feeding
//  the sel_coeffs CDC mux. Two requesters (A, B) compete for the active coefficient set.
//  - Switches are break-before-make: the old grant drops, o_sel toggles, then settle time
//    lets the destination-domain synchronizer capture stable data before the new grant.
//  - A minimum dwell time between switches prevents select thrash across the CDC boundary.
// PARAMETERS
//  GUARD_CYCLES   2   cycles from old-grant drop to o_sel toggle (>=1)
//  SETTLE_CYCLES  4   cycles from o_sel toggle to new grant (>=1; covers 2-FF sync + margin)
//  MIN_DWELL      8   cycles after a completed switch before the next may start (>=0)
//  CNT_NB         16  width of o_switch_count
// PORTS
//  i_clock         in   1       single clock, rising edge
//  i_reset         in   1       asynchronous, active-low reset
//  i_req_a         in   1       level request: requester A wants its coeffs active
//  i_req_b         in   1       level request: requester B wants its coeffs active
//  i_freeze        in   1       holds arbiter in IDLE; no new switch starts
//  o_sel           out  1       0 = coeffs A active, 1 = coeffs B active (to sel_coeffs)
//  o_gnt_a         out  1       A owns the coefficient path and may update i_coeffs_a
//  o_gnt_b         out  1       B owns the coefficient path and may update i_coeffs_b
//  o_busy          out  1       switch in progress (state != IDLE)
//  o_done          out  1       1-cycle pulse: switch completed, new grant asserted
//  o_switch_count  out  CNT_NB  completed-switch counter, wraps at 2^CNT_NB
// BEHAVIOUR
//  - All outputs registered. Reset (async assert, sync deassert at edge): state=IDLE,
//    o_sel=0, o_gnt_a=1, o_gnt_b=0, o_busy=0, o_done=0, o_switch_count=0,
//    dwell counter=MIN_DWELL (first switch needs no dwell).
//  - Owner = requester selected by o_sel. Qualifying request: non-owner req high AND
//    dwell==MIN_DWELL AND i_freeze==0 AND state==IDLE. Owner's own req is ignored, so
//    with both reqs high the non-owner wins (alternation).
//  - FSM IDLE -> GUARD -> SETTLE -> IDLE. Qualifying request sampled at edge e0:
//    e0: owner gnt ->0 (both gnts 0), o_busy->1, state GUARD.
//    e0+GUARD_CYCLES: o_sel toggles, state SETTLE.
//    e0+GUARD_CYCLES+SETTLE_CYCLES: new owner gnt->1, o_done=1 for one cycle,
//    o_switch_count+1, dwell->0, o_busy->0, state IDLE.
//  - Abort: requester req low at any edge in GUARD -> next edge restores old owner's gnt,
//    IDLE, o_sel unchanged, no o_done, count and dwell unchanged.
//  - Once o_sel has toggled (SETTLE), switch always completes; req/freeze ignored.
//  - i_freeze in GUARD/SETTLE has no effect; it only blocks leaving IDLE.
//  - Dwell counter increments every cycle in IDLE, saturates at MIN_DWELL. MIN_DWELL=0
//    allows back-to-back switches.
//  - Exactly one of o_gnt_a/o_gnt_b is 1 in IDLE; both 0 in GUARD and SETTLE.
//  - Phase counter width $clog2(max(GUARD,SETTLE)+1); no overflow possible.
//  - o_switch_count wraps 2^CNT_NB-1 -> 0 silently.
//  - Reset mid-switch: immediate return to reset values, including o_sel=0.
// STRUCTURE
//  - coeff_sel_pkg: typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_SETTLE} arb_state_t;
//    localparams SEL_A=1'b0, SEL_B=1'b1.
//  - Sub-module sat_counter (#(NB, MAX), clear/enable, saturating) for the dwell
//    counter; phase counter and FSM inline.
// TESTING (defaults G=2, S=4, D=8; bench also instantiates sel_coeffs for end-to-end)
//  1 Reset: assert i_reset=0 -> o_sel=0, o_gnt_a=1, o_gnt_b=0, o_busy=0, count=0.
//  2 Basic switch: i_req_b=1 at e0 -> gnt_a=0 at e0, o_sel=1 at e0+2, gnt_b=1 and
//    o_done pulse at e0+6, count=1; downstream o_coeffs equals i_coeffs_b.
//  3 Dwell: i_req_a=1 right after test 2 -> no action for 8 IDLE cycles, then switch
//    to A; o_sel=0 at start+2, count=2.
//  4 Abort: i_req_b=1 one cycle then 0 during GUARD -> gnt_a back to 1, o_sel stays 0,
//    no o_done, count unchanged.
//  5 Freeze/contention: i_freeze=1 with both reqs high for 20 cycles -> no change;
//    release freeze -> non-owner wins; freeze asserted in SETTLE -> switch completes.
//  6 Reset mid-SETTLE (o_sel=1) -> all outputs return to reset values asynchronously;
//    wrap: preload near 2^16-1 (or CNT_NB=4, 16 switches) -> count returns to 0.

Source files
------------

// File: rtl/coeff_sel_pkg.sv
// Shared types and select encodings for the coefficient-select arbiter.
package coeff_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GUARD  = 2'd1,
    ST_SETTLE = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at MAX; comes out of reset already saturated.
module sat_counter #(
  parameter int NB  = 4,
  parameter int MAX = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [NB-1:0] cnt_o
);

  localparam logic [NB-1:0] MAX_V = NB'(MAX);

  logic [NB-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= MAX_V;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/coeff_sel_arbiter.sv
// Break-before-make arbiter owning the coefficient-source select of a CDC mux.
// Sequence: drop old grant, wait, toggle select, let the far-side sync settle, grant.
module coeff_sel_arbiter
  import coeff_sel_pkg::*;
#(
  parameter int GUARD_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int MIN_DWELL     = 8,
  parameter int CNT_NB        = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req_a,
  input  logic              i_req_b,
  input  logic              i_freeze,
  output logic              o_sel,
  output logic              o_gnt_a,
  output logic              o_gnt_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_NB-1:0] o_switch_count
);

  localparam int PH_MAX = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int PH_NB  = (PH_MAX > 1) ? $clog2(PH_MAX + 1) : 1;
  localparam int DW_NB  = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

  localparam logic [PH_NB-1:0] GUARD_LAST  = PH_NB'(GUARD_CYCLES - 1);
  localparam logic [PH_NB-1:0] SETTLE_LAST = PH_NB'(SETTLE_CYCLES - 1);
  localparam logic [DW_NB-1:0] DWELL_FULL  = DW_NB'(MIN_DWELL);

  arb_state_t        state_q, state_d;
  logic [PH_NB-1:0]  ph_q, ph_d;
  logic              sel_q, sel_d;
  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_NB-1:0] cnt_q, cnt_d;

  logic              req_new;
  logic              dwell_clr;
  logic              dwell_en;
  logic [DW_NB-1:0]  dwell_cnt;

  // The owner's own request never matters; only the other side can pull the select.
  assign req_new = (sel_q == SEL_B) ? i_req_a : i_req_b;

  sat_counter #(
    .NB  (DW_NB),
    .MAX (MIN_DWELL)
  ) u_dwell (
    .clk_i  (i_clock),
    .rst_ni (i_reset),
    .clr_i  (dwell_clr),
    .en_i   (dwell_en),
    .cnt_o  (dwell_cnt)
  );

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    sel_d     = sel_q;
    gnt_a_d   = gnt_a_q;
    gnt_b_d   = gnt_b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    dwell_clr = 1'b0;
    dwell_en  = (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (req_new && (dwell_cnt == DWELL_FULL) && !i_freeze) begin
          state_d = ST_GUARD;
          ph_d    = '0;
          gnt_a_d = 1'b0;
          gnt_b_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_GUARD: begin
        // Select has not moved yet, so a withdrawn request can still back out cleanly.
        if (!req_new) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          gnt_a_d = (sel_q == SEL_A);
          gnt_b_d = (sel_q == SEL_B);
        end else if (ph_q == GUARD_LAST) begin
          state_d = ST_SETTLE;
          ph_d    = '0;
          sel_d   = ~sel_q;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      ST_SETTLE: begin
        if (ph_q == SETTLE_LAST) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          gnt_a_d   = (sel_q == SEL_A);
          gnt_b_d   = (sel_q == SEL_B);
          done_d    = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          dwell_clr = 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        gnt_a_d = (sel_q == SEL_A);
        gnt_b_d = (sel_q == SEL_B);
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      sel_q   <= SEL_A;
      gnt_a_q <= 1'b1;
      gnt_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      sel_q   <= sel_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_sel          = sel_q;
  assign o_gnt_a        = gnt_a_q;
  assign o_gnt_b        = gnt_b_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_switch_count = cnt_q;

endmodule

// File: tb/tb_coeff_sel_arbiter.sv
// Bench for coeff_sel_arbiter: directed scenarios plus randomized traffic against
// an event-schedule reference model; a small second instance exercises counter wrap.
module tb_coeff_sel_arbiter;

  localparam int G = 2;
  localparam int S = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, freeze;
  logic        sel, gnt_a, gnt_b, busy, done;
  logic [15:0] cnt;

  logic        req2;
  logic        sel2, gnt2_a, gnt2_b, busy2, done2;
  logic [3:0]  cnt2;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: a switch is a scheduled event started at edge m_t0.
  int          n;
  int          m_t0;
  int          m_last_done;
  bit          m_active, m_swapped, m_tgt, m_sel, m_done;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  coeff_sel_arbiter #(
    .GUARD_CYCLES (G),
    .SETTLE_CYCLES(S),
    .MIN_DWELL    (D),
    .CNT_NB       (16)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_req_a       (req_a),
    .i_req_b       (req_b),
    .i_freeze      (freeze),
    .o_sel         (sel),
    .o_gnt_a       (gnt_a),
    .o_gnt_b       (gnt_b),
    .o_busy        (busy),
    .o_done        (done),
    .o_switch_count(cnt)
  );

  coeff_sel_arbiter #(
    .GUARD_CYCLES (1),
    .SETTLE_CYCLES(1),
    .MIN_DWELL    (0),
    .CNT_NB       (4)
  ) dut_wrap (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_req_a       (req2),
    .i_req_b       (req2),
    .i_freeze      (1'b0),
    .o_sel         (sel2),
    .o_gnt_a       (gnt2_a),
    .o_gnt_b       (gnt2_b),
    .o_busy        (busy2),
    .o_done        (done2),
    .o_switch_count(cnt2)
  );

  task automatic model_reset();
    n           = 0;
    m_t0        = 0;
    m_last_done = -1000;
    m_active    = 0;
    m_swapped   = 0;
    m_tgt       = 0;
    m_sel       = 0;
    m_done      = 0;
    m_cnt       = 16'd0;
  endtask

  task automatic model_step();
    logic r;
    m_done = 0;
    if (m_active) begin
      r = m_tgt ? req_b : req_a;
      if (!m_swapped && !r) begin
        m_active = 0;
      end else if (n - m_t0 == G) begin
        m_sel     = m_tgt;
        m_swapped = 1;
      end else if (n - m_t0 == G + S) begin
        m_active    = 0;
        m_done      = 1;
        m_cnt       = m_cnt + 16'd1;
        m_last_done = n;
      end
    end else begin
      r = m_sel ? req_a : req_b;
      if (r && !freeze && (n - m_last_done > D)) begin
        m_active  = 1;
        m_t0      = n;
        m_tgt     = !m_sel;
        m_swapped = 0;
      end
    end
    n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_a = 0; req_b = 0; freeze = 0; req2 = 0;
    repeat (2) @(negedge clk);
    vectors++; if (sel !== 1'b0)    begin miscompares++; $display("FAIL reset_sel: got %b want 0", sel); end
    vectors++; if (gnt_a !== 1'b1)  begin miscompares++; $display("FAIL reset_gnt_a: got %b want 1", gnt_a); end
    vectors++; if (gnt_b !== 1'b0)  begin miscompares++; $display("FAIL reset_gnt_b: got %b want 0", gnt_b); end
    vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0)   begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (cnt !== 16'd0)   begin miscompares++; $display("FAIL reset_count: got %0d want 0", cnt); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_switch();
    req_b = 1;
    tick();  // e0
    vectors++; if ({gnt_a, gnt_b, busy} !== 3'b001) begin miscompares++; $display("FAIL basic_e0: got gnt_a/gnt_b/busy=%b want 001", {gnt_a, gnt_b, busy}); end
    tick();
    vectors++; if (sel !== 1'b0) begin miscompares++; $display("FAIL basic_sel_early: got %b want 0", sel); end
    tick();  // e0+2
    vectors++; if (sel !== 1'b1) begin miscompares++; $display("FAIL basic_sel_toggle: got %b want 1", sel); end
    repeat (3) tick();
    vectors++; if (gnt_b !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL basic_early_grant: got gnt_b=%b done=%b want 0 0", gnt_b, done); end
    tick();  // e0+6
    vectors++; if ({gnt_a, gnt_b, busy, done} !== 4'b0101) begin miscompares++; $display("FAIL basic_complete: got %b want 0101", {gnt_a, gnt_b, busy, done}); end
    vectors++; if (cnt !== 16'd1) begin miscompares++; $display("FAIL basic_count: got %0d want 1", cnt); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_dwell();
    int early = 0;
    req_b = 0; req_a = 1;
    repeat (7) begin
      tick();
      if (busy !== 1'b0) early++;
    end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL dwell_hold: got %0d busy cycles want 0", early); end
    tick();
    vectors++; if (busy !== 1'b1 || gnt_b !== 1'b0) begin miscompares++; $display("FAIL dwell_start: got busy=%b gnt_b=%b want 1 0", busy, gnt_b); end
    repeat (2) tick();
    vectors++; if (sel !== 1'b0) begin miscompares++; $display("FAIL dwell_sel: got %b want 0", sel); end
    repeat (4) tick();
    vectors++; if (cnt !== 16'd2 || gnt_a !== 1'b1 || done !== 1'b1) begin miscompares++; $display("FAIL dwell_complete: got count=%0d gnt_a=%b done=%b want 2 1 1", cnt, gnt_a, done); end
    req_a = 0;
  endtask

  task automatic test_abort();
    int dones = 0;
    repeat (10) tick();
    req_b = 1;
    tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_start: got busy=%b want 1", busy); end
    req_b = 0;
    tick();
    vectors++; if ({sel, gnt_a, gnt_b, busy} !== 4'b0100) begin miscompares++; $display("FAIL abort_restore: got %b want 0100", {sel, gnt_a, gnt_b, busy}); end
    repeat (8) begin
      tick();
      if (done !== 1'b0 || sel !== 1'b0) dones++;
    end
    vectors++; if (dones != 0) begin miscompares++; $display("FAIL abort_quiet: got %0d bad cycles want 0", dones); end
    vectors++; if (cnt !== 16'd2) begin miscompares++; $display("FAIL abort_count: got %0d want 2", cnt); end
  endtask

  task automatic test_freeze();
    int moved = 0;
    freeze = 1; req_a = 1; req_b = 1;
    repeat (20) begin
      tick();
      if ({sel, gnt_a, gnt_b, busy} !== 4'b0100) moved++;
    end
    vectors++; if (moved != 0) begin miscompares++; $display("FAIL freeze_hold: got %0d changed cycles want 0", moved); end
    freeze = 0;
    tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL freeze_release: got busy=%b want 1", busy); end
    repeat (2) tick();
    vectors++; if (sel !== 1'b1) begin miscompares++; $display("FAIL contention_sel: got %b want 1 (B wins)", sel); end
    freeze = 1; req_b = 0;
    repeat (4) tick();
    vectors++; if ({gnt_b, done} !== 2'b11 || cnt !== 16'd3) begin miscompares++; $display("FAIL freeze_in_settle: got gnt_b=%b done=%b count=%0d want 1 1 3", gnt_b, done, cnt); end
    freeze = 0; req_a = 0;
  endtask

  task automatic test_random();
    logic [20:0] got, exp;
    int bad = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) req_a = ~req_a;
      if ($urandom_range(0, 5) == 0) req_b = ~req_b;
      if ($urandom_range(0, 11) == 0) freeze = ~freeze;
      tick();
      got = {sel, gnt_a, gnt_b, busy, done, cnt};
      exp = {m_sel, !m_active && !m_sel, !m_active && m_sel, m_active, m_done, m_cnt};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        if (bad < 10) $display("FAIL random_cycle_%0d: got %h want %h", i, got, exp);
        bad++;
      end
    end
    req_a = 0; req_b = 0; freeze = 0;
  endtask

  task automatic test_reset_mid_settle();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    req_b = 1;
    repeat (4) tick();
    vectors++; if (sel !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL settle_setup: got sel=%b busy=%b want 1 1", sel, busy); end
    #2 rst_n = 0;
    #1;
    vectors++; if ({sel, gnt_a, gnt_b, busy, done} !== 5'b01000 || cnt !== 16'd0) begin
      miscompares++; $display("FAIL async_reset: got %b count=%0d want 01000 count=0", {sel, gnt_a, gnt_b, busy, done}, cnt);
    end
    req_b = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_wrap();
    req2 = 1;
    repeat (45) tick();
    vectors++; if (cnt2 !== 4'd15 || busy2 !== 1'b0 || done2 !== 1'b1) begin miscompares++; $display("FAIL wrap_15: got count=%0d busy=%b done=%b want 15 0 1", cnt2, busy2, done2); end
    repeat (3) tick();
    vectors++; if (cnt2 !== 4'd0 || done2 !== 1'b1) begin miscompares++; $display("FAIL wrap_0: got count=%0d done=%b want 0 1", cnt2, done2); end
    vectors++; if ({sel2, gnt2_a, gnt2_b} !== 3'b010) begin miscompares++; $display("FAIL wrap_owner: got %b want 010", {sel2, gnt2_a, gnt2_b}); end
    req2 = 0;
  endtask

  initial begin
    test_reset();
    test_basic_switch();
    test_dwell();
    test_abort();
    test_freeze();
    test_random();
    test_reset_mid_settle();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
